// File: rtl/pipe_skid_buffer_pkg.sv
// Shared pipeline types for the two-entry skid stage.
package pipe_skid_buffer_pkg;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/pipe_skid_buffer.sv
// Two-entry registered valid/ready stage; in_ready is decoded from state only,
// so there is no combinational path from out_ready back to in_ready.
module pipe_skid_buffer
  import pipe_skid_buffer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  skid_state_t      state_q, state_d;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             in_fire, out_fire;
  logic             load_main, load_skid, main_from_skid;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (state_q != FULL);
  assign occupancy = 2'(state_q);
  assign out_data  = main_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d   = BUSY;
          load_main = 1'b1;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          load_main = 1'b1;
        end else if (in_fire) begin
          state_d   = FULL;
          load_skid = 1'b1;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_d        = BUSY;
          load_main      = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush wins over any handshake and leaves the data registers untouched.
    if (flush) begin
      state_d   = EMPTY;
      load_main = 1'b0;
      load_skid = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load_main) main_q <= main_from_skid ? skid_q : in_data;
      if (load_skid) skid_q <= in_data;
    end
  end

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Directed and randomized checks of the two-entry skid stage.
module tb_pipe_skid_buffer;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;

  int checks = 0;
  int fails  = 0;

  pipe_skid_buffer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    in_data   = '0;
  endtask

  task automatic test_reset_values();
    rst = 1'b1;
    idle();
    #2;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0 || out_data !== 32'h0) begin
      fails++;
      $display("FAIL reset_values: out_valid=%b in_ready=%b occ=%0d data=%h, want 0 1 0 00000000",
               out_valid, in_ready, occupancy, out_data);
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    checks++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL stream_start_empty: out_valid=%b want 0", out_valid);
    end
    for (int i = 1; i <= 16; i++) begin
      in_data = 32'(i);
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'(i) || in_ready !== 1'b1 || occupancy !== 2'd1) begin
        fails++;
        $display("FAIL stream_%0d: valid=%b data=%h ready=%b occ=%0d, want 1 %h 1 1",
                 i, out_valid, out_data, in_ready, occupancy, 32'(i));
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      fails++;
      $display("FAIL stream_drain: valid=%b occ=%0d, want 0 0", out_valid, occupancy);
    end
    idle();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hAAAA0000;
    step();
    checks++;
    if (occupancy !== 2'd1 || in_ready !== 1'b1 || out_data !== 32'hAAAA0000) begin
      fails++;
      $display("FAIL bp_busy: occ=%0d ready=%b data=%h, want 1 1 aaaa0000", occupancy, in_ready, out_data);
    end
    in_data = 32'hBBBB0000;
    step();
    checks++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'hAAAA0000) begin
      fails++;
      $display("FAIL bp_full: occ=%0d ready=%b data=%h, want 2 0 aaaa0000", occupancy, in_ready, out_data);
    end
    in_data = 32'hCCCC0000;
    step();
    checks++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'hAAAA0000 || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL bp_hold: occ=%0d ready=%b data=%h valid=%b, want 2 0 aaaa0000 1",
               occupancy, in_ready, out_data, out_valid);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (occupancy !== 2'd1 || out_data !== 32'hBBBB0000) begin
      fails++;
      $display("FAIL bp_second: occ=%0d data=%h, want 1 bbbb0000", occupancy, out_data);
    end
    step();
    checks++;
    if (occupancy !== 2'd1 || out_data !== 32'hCCCC0000) begin
      fails++;
      $display("FAIL bp_third: occ=%0d data=%h, want 1 cccc0000", occupancy, out_data);
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_drain: valid=%b want 0", out_valid);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1;
    in_data  = 32'h11;
    step();
    in_data   = 32'h22;
    out_ready = 1'b1;
    step();
    checks++;
    if (occupancy !== 2'd1 || out_data !== 32'h22 || out_valid !== 1'b1 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL simultaneous: occ=%0d data=%h valid=%b ready=%b, want 1 00000022 1 1",
               occupancy, out_data, out_valid, in_ready);
    end
    in_valid = 1'b0;
    step();
    idle();
  endtask

  task automatic test_flush();
    in_valid = 1'b1;
    in_data  = 32'h1;
    step();
    in_data = 32'h2;
    step();
    checks++;
    if (occupancy !== 2'd2) begin
      fails++;
      $display("FAIL flush_setup: occ=%0d want 2", occupancy);
    end
    in_data = 32'hDEAD;
    flush   = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL flush_empty: valid=%b occ=%0d ready=%b, want 0 0 1", out_valid, occupancy, in_ready);
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        fails++;
        $display("FAIL flush_no_dead: valid=%b data=%h, want valid 0", out_valid, out_data);
      end
    end
    idle();
  endtask

  task automatic test_reset_async();
    in_valid = 1'b1;
    in_data  = 32'h7;
    step();
    in_data = 32'h8;
    step();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0 || out_data !== 32'h0) begin
      fails++;
      $display("FAIL reset_async: valid=%b ready=%b occ=%0d data=%h, want 0 1 0 00000000",
               out_valid, in_ready, occupancy, out_data);
    end
    step();
    rst      = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'h55;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h55) begin
      fails++;
      $display("FAIL reset_release_accept: valid=%b data=%h, want 1 00000055", out_valid, out_data);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    idle();
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] q[$];
    logic             exp_in_ready, fire_in, fire_out;
    int               rnd_fails = 0;
    q.delete();
    in_valid = 1'b0;
    in_data  = $urandom;
    for (int c = 0; c < 10000; c++) begin
      // Upstream keeps its payload stable until it is accepted.
      if (!in_valid) in_data = $urandom;
      in_valid  = ($urandom_range(3, 0) != 0);
      out_ready = ($urandom_range(2, 0) != 0);
      flush     = ($urandom_range(24, 0) == 0);
      @(negedge clk);
      exp_in_ready = (q.size() < 2);
      checks++;
      if (out_valid !== (q.size() != 0) || in_ready !== exp_in_ready ||
          occupancy !== 2'(q.size()) || occupancy === 2'd3) begin
        fails++;
        rnd_fails++;
        if (rnd_fails < 10)
          $display("FAIL random_state cyc %0d: valid=%b ready=%b occ=%0d, want model size %0d",
                   c, out_valid, in_ready, occupancy, q.size());
      end
      fire_out = out_ready && (q.size() != 0);
      fire_in  = in_valid && exp_in_ready;
      if (fire_out) begin
        checks++;
        if (out_data !== q[0]) begin
          fails++;
          rnd_fails++;
          if (rnd_fails < 10)
            $display("FAIL random_data cyc %0d: got %h want %h", c, out_data, q[0]);
        end
        void'(q.pop_front());
      end
      if (flush) q.delete();
      else if (fire_in) q.push_back(in_data);
      step();
      if (fire_in) in_data = $urandom;
    end
    idle();
    step();
  endtask

  initial begin
    test_reset_values();
    test_streaming();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_async();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
